axil_csr_slave: RTL and testbench

AXIL_CSR_SLAVE -- requirements
Module: axil_csr_slave
Interface
REQ-001 SHALL have parameter ADDR_W, default 12, AXI4-Lite byte-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_axi_csrs_awaddr  input  ADDR_W  write address.
REQ-005 SHALL have port s_axi_csrs_awvalid  input  1  write address valid.
REQ-006 SHALL have port s_axi_csrs_awready  output  1  write address ready.
REQ-007 SHALL have port s_axi_csrs_wdata  input  32  write data.
REQ-008 SHALL have port s_axi_csrs_wstrb  input  4  byte enables; bit k covers wdata[8k+7:8k].
REQ-009 SHALL have port s_axi_csrs_wvalid  input  1  write data valid.
REQ-010 SHALL have port s_axi_csrs_wready  output  1  write data ready.
REQ-011 SHALL have port s_axi_csrs_bresp  output  2  write response, OKAY=00, SLVERR=10.
REQ-012 SHALL have port s_axi_csrs_bvalid  output  1  write response valid.
REQ-013 SHALL have port s_axi_csrs_bready  input  1  write response accepted.
REQ-014 SHALL have port s_axi_csrs_araddr  input  ADDR_W  read address.
REQ-015 SHALL have port s_axi_csrs_arvalid  input  1  read address valid.
REQ-016 SHALL have port s_axi_csrs_arready  output  1  read address ready.
REQ-017 SHALL have port s_axi_csrs_rdata  output  32  read data.
REQ-018 SHALL have port s_axi_csrs_rresp  output  2  read response, OKAY/SLVERR.
REQ-019 SHALL have port s_axi_csrs_rvalid  output  1  read data valid.
REQ-020 SHALL have port s_axi_csrs_rready  input  1  read data accepted.
REQ-021 SHALL have ports command, rxaddr, txaddr, t, t_len, loading  output  32 each  write registers at byte offsets 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14.
REQ-022 SHALL have ports status, lsb_n, lsb_r_n, lsb_r2_n  input  32 each  core read values at byte offsets 0x00, 0x04, 0x08, 0x0C.
Function
REQ-023 Decode SHALL use addr[ADDR_W-1:2]; addr[1:0] ignored; offsets >= 0x20 are out of range.
REQ-024 Write FSM SHALL have states W_IDLE (awready=wready=1), W_HAVE_A (only wready=1), W_HAVE_D (only awready=1), and W_RESP (bvalid=1, both readies 0).
REQ-025 W_IDLE SHALL go to W_RESP when AW and W handshake on the same edge, to W_HAVE_A on AW only, and to W_HAVE_D on W only; W_HAVE_A/W_HAVE_D SHALL go to W_RESP on the missing handshake.
REQ-026 The register update SHALL occur on the edge that enters W_RESP, bytes gated by wstrb; bvalid SHALL assert the next cycle (latency 1 cycle from the last handshake).
REQ-027 W_RESP SHALL hold bvalid/bresp stable until bvalid&&bready, then return to W_IDLE; a master that keeps awvalid/wvalid high after its handshake SHALL NOT cause a second capture.
REQ-028 A write to offset 0x18 or 0x1C SHALL change nothing and return OKAY; an out-of-range write SHALL change nothing and return SLVERR.
REQ-029 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (rvalid=1, arready=0); the AR handshake SHALL register rdata/rresp, and R_DATA SHALL hold them until rvalid&&rready, then return to R_IDLE.
REQ-030 The read map SHALL be: 0x00 status, 0x04 lsb_n, 0x08 lsb_r_n, 0x0C lsb_r2_n, 0x10 t_len readback, 0x14 loading readback, 0x18/0x1C zero with OKAY, out of range zero with SLVERR.
REQ-031 Read and write paths SHALL be independent; a read of 0x10/0x14 whose AR handshake is on the same edge as a write to that offset SHALL return the pre-write value.
Reset
REQ-032 On resetn=0, asynchronously: all six write registers =0, bvalid=rvalid=0, bresp=rresp=00, rdata=0, both FSMs in IDLE; the readies SHALL assert only after resetn is released.
REQ-033 Reset mid-transaction SHALL abort the transaction silently, with no partial register update and no stale response after release.
Structure
REQ-034 Package axil_csr_pkg SHALL hold the register offset constants, the RESP_OKAY/RESP_SLVERR codes, and the write/read FSM state enums.
REQ-035 Sub-module axil_csr_wr_fsm SHALL implement the AW/W/B capture logic; the register file and the read path SHALL stay in the top module.
Verification
REQ-036 AW+W together, addr 0x04, data 0x00000100, wstrb F -> bvalid one cycle later with bresp 00, and rxaddr=0x100.
REQ-037 W two cycles before AW, addr 0x14, data 0x9, wstrb 1 -> loading=0x9 after the AW edge; read 0x14 -> 0x00000009 OKAY.
REQ-038 Write 0x0C with data 0xAABBCCDD, wstrb 0101, prior value 0 -> t=0x00BB00DD.
REQ-039 status=0x1 and read of 0x00 with rready held low 5 cycles -> rvalid/rdata 0x1 stable throughout and arready 0 until the handshake.
REQ-040 Write 0x40 -> SLVERR with no register change; read 0x40 -> rdata 0, rresp 10; resetn pulse during W_HAVE_A -> all outputs 0 and the next write completes normally.

---
 rtl/axil_csr_pkg.sv | 34 +++
 rtl/axil_csr_wr_fsm.sv | 120 ++++++++++++
 rtl/axil_csr_slave.sv | 176 +++++++++++++++++
 tb/tb_axil_csr_slave.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_csr_pkg.sv
// Shared constants, response codes and FSM state types for the AXI4-Lite CSR slave.
package axil_csr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offsets; write and read maps share the lower four slots.
  localparam int unsigned OFF_COMMAND  = 'h00;
  localparam int unsigned OFF_RXADDR   = 'h04;
  localparam int unsigned OFF_TXADDR   = 'h08;
  localparam int unsigned OFF_T        = 'h0C;
  localparam int unsigned OFF_T_LEN    = 'h10;
  localparam int unsigned OFF_LOADING  = 'h14;
  localparam int unsigned OFF_STATUS   = 'h00;
  localparam int unsigned OFF_LSB_N    = 'h04;
  localparam int unsigned OFF_LSB_R_N  = 'h08;
  localparam int unsigned OFF_LSB_R2_N = 'h0C;
  localparam int unsigned CSR_SPAN     = 'h20;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_wr_fsm.sv
// AXI4-Lite write channel capture: joins AW and W in any order, emits a one-cycle
// commit strobe to the register file and holds the B response until accepted.
module axil_csr_wr_fsm
  import axil_csr_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-3:0] aw_idx,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              wr_en,
  output logic [ADDR_W-3:0] wr_idx,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb
);

  wr_state_e         state_q, state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        strb_q, strb_d;
  logic              aw_hs, w_hs;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    bresp_d = bresp_q;
    wr_en   = 1'b0;
    wr_idx  = addr_q;
    wr_data = data_q;
    wr_strb = strb_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = W_RESP;
          wr_en   = 1'b1;
          wr_idx  = aw_idx;
          wr_data = wdata;
          wr_strb = wstrb;
        end else if (aw_hs) begin
          state_d = W_HAVE_A;
          addr_d  = aw_idx;
        end else if (w_hs) begin
          state_d = W_HAVE_D;
          data_d  = wdata;
          strb_d  = wstrb;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          state_d = W_RESP;
          wr_en   = 1'b1;
          wr_data = wdata;
          wr_strb = wstrb;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          state_d = W_RESP;
          wr_en   = 1'b1;
          wr_idx  = aw_idx;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
    if (wr_en) bresp_d = (32'({wr_idx, 2'b00}) < CSR_SPAN) ? RESP_OKAY : RESP_SLVERR;
    // Readies follow the next state so they stay low for the first cycle out of reset.
    awready_d = (state_d == W_IDLE) || (state_d == W_HAVE_D);
    wready_d  = (state_d == W_IDLE) || (state_d == W_HAVE_A);
    bvalid_d  = (state_d == W_RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR slave: six byte-writable control registers plus a read map of
// core status inputs and register readbacks; read and write paths are independent.
module axil_csr_slave
  import axil_csr_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_axi_csrs_awaddr,
  input  logic              s_axi_csrs_awvalid,
  output logic              s_axi_csrs_awready,
  input  logic [31:0]       s_axi_csrs_wdata,
  input  logic [3:0]        s_axi_csrs_wstrb,
  input  logic              s_axi_csrs_wvalid,
  output logic              s_axi_csrs_wready,
  output logic [1:0]        s_axi_csrs_bresp,
  output logic              s_axi_csrs_bvalid,
  input  logic              s_axi_csrs_bready,
  input  logic [ADDR_W-1:0] s_axi_csrs_araddr,
  input  logic              s_axi_csrs_arvalid,
  output logic              s_axi_csrs_arready,
  output logic [31:0]       s_axi_csrs_rdata,
  output logic [1:0]        s_axi_csrs_rresp,
  output logic              s_axi_csrs_rvalid,
  input  logic              s_axi_csrs_rready,
  output logic [31:0]       command,
  output logic [31:0]       rxaddr,
  output logic [31:0]       txaddr,
  output logic [31:0]       t,
  output logic [31:0]       t_len,
  output logic [31:0]       loading,
  input  logic [31:0]       status,
  input  logic [31:0]       lsb_n,
  input  logic [31:0]       lsb_r_n,
  input  logic [31:0]       lsb_r2_n
);

  logic              wr_en;
  logic [ADDR_W-3:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_off, rd_off;
  logic              unused_addr_bits;

  logic [31:0] command_q, command_d, rxaddr_q, rxaddr_d, txaddr_q, txaddr_d;
  logic [31:0] t_q, t_d, t_len_q, t_len_d, loading_q, loading_d;

  rd_state_e   rd_state_q, rd_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  assign unused_addr_bits = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0]};

  axil_csr_wr_fsm #(.ADDR_W(ADDR_W)) u_wr_fsm (
    .clk     (clk),
    .resetn  (resetn),
    .aw_idx  (s_axi_csrs_awaddr[ADDR_W-1:2]),
    .awvalid (s_axi_csrs_awvalid),
    .awready (s_axi_csrs_awready),
    .wdata   (s_axi_csrs_wdata),
    .wstrb   (s_axi_csrs_wstrb),
    .wvalid  (s_axi_csrs_wvalid),
    .wready  (s_axi_csrs_wready),
    .bresp   (s_axi_csrs_bresp),
    .bvalid  (s_axi_csrs_bvalid),
    .bready  (s_axi_csrs_bready),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  assign wr_off = 32'({wr_idx, 2'b00});
  assign rd_off = 32'({s_axi_csrs_araddr[ADDR_W-1:2], 2'b00});

  always_comb begin
    command_d = command_q;
    rxaddr_d  = rxaddr_q;
    txaddr_d  = txaddr_q;
    t_d       = t_q;
    t_len_d   = t_len_q;
    loading_d = loading_q;
    if (wr_en) begin
      case (wr_off)
        OFF_COMMAND: command_d = merge_strb(command_q, wr_data, wr_strb);
        OFF_RXADDR:  rxaddr_d  = merge_strb(rxaddr_q, wr_data, wr_strb);
        OFF_TXADDR:  txaddr_d  = merge_strb(txaddr_q, wr_data, wr_strb);
        OFF_T:       t_d       = merge_strb(t_q, wr_data, wr_strb);
        OFF_T_LEN:   t_len_d   = merge_strb(t_len_q, wr_data, wr_strb);
        OFF_LOADING: loading_d = merge_strb(loading_q, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  // Readback uses the _q values, so a same-edge write is not yet visible.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_csrs_arvalid && arready_q) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = (rd_off < CSR_SPAN) ? RESP_OKAY : RESP_SLVERR;
          case (rd_off)
            OFF_STATUS:   rdata_d = status;
            OFF_LSB_N:    rdata_d = lsb_n;
            OFF_LSB_R_N:  rdata_d = lsb_r_n;
            OFF_LSB_R2_N: rdata_d = lsb_r2_n;
            OFF_T_LEN:    rdata_d = t_len_q;
            OFF_LOADING:  rdata_d = loading_q;
            default:      rdata_d = '0;
          endcase
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_csrs_rready) begin
          rd_state_d = R_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      command_q  <= '0;
      rxaddr_q   <= '0;
      txaddr_q   <= '0;
      t_q        <= '0;
      t_len_q    <= '0;
      loading_q  <= '0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      command_q  <= command_d;
      rxaddr_q   <= rxaddr_d;
      txaddr_q   <= txaddr_d;
      t_q        <= t_d;
      t_len_q    <= t_len_d;
      loading_q  <= loading_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign command            = command_q;
  assign rxaddr             = rxaddr_q;
  assign txaddr             = txaddr_q;
  assign t                  = t_q;
  assign t_len              = t_len_q;
  assign loading            = loading_q;
  assign s_axi_csrs_arready = arready_q;
  assign s_axi_csrs_rvalid  = rvalid_q;
  assign s_axi_csrs_rdata   = rdata_q;
  assign s_axi_csrs_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_csr_slave.sv
// Scoreboarded random + directed bench for axil_csr_slave against a register-map model.
module tb_axil_csr_slave;

  logic        clk, resetn;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] command, rxaddr, txaddr, t, t_len, loading;
  logic [31:0] status, lsb_n, lsb_r_n, lsb_r2_n;

  axil_csr_slave #(.ADDR_W(12)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_csrs_awaddr(awaddr), .s_axi_csrs_awvalid(awvalid), .s_axi_csrs_awready(awready),
    .s_axi_csrs_wdata(wdata), .s_axi_csrs_wstrb(wstrb), .s_axi_csrs_wvalid(wvalid),
    .s_axi_csrs_wready(wready), .s_axi_csrs_bresp(bresp), .s_axi_csrs_bvalid(bvalid),
    .s_axi_csrs_bready(bready), .s_axi_csrs_araddr(araddr), .s_axi_csrs_arvalid(arvalid),
    .s_axi_csrs_arready(arready), .s_axi_csrs_rdata(rdata), .s_axi_csrs_rresp(rresp),
    .s_axi_csrs_rvalid(rvalid), .s_axi_csrs_rready(rready),
    .command(command), .rxaddr(rxaddr), .txaddr(txaddr), .t(t), .t_len(t_len),
    .loading(loading), .status(status), .lsb_n(lsb_n), .lsb_r_n(lsb_r_n), .lsb_r2_n(lsb_r2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] mregs [6];
  logic [1:0]  bq [$];
  logic [31:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  bit          r_hold = 1'b0;
  logic        b_stall = 1'b0, r_stall = 1'b0;
  logic [1:0]  b_prev, r_prev_resp;
  logic [31:0] r_prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Register map model: word index of the byte offset selects the register.
  task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int unsigned off;
    off = int'(addr) & 'hFFC;
    if (off >= 32) resp = 2'b10;
    else begin
      resp = 2'b00;
      if (off < 24)
        for (int b = 0; b < 4; b++)
          if (strb[b]) mregs[off/4][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic model_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int unsigned off;
    off  = int'(addr) & 'hFFC;
    data = 32'h0;
    resp = (off >= 32) ? 2'b10 : 2'b00;
    case (off)
      0:  data = status;
      4:  data = lsb_n;
      8:  data = lsb_r_n;
      12: data = lsb_r2_n;
      16: data = mregs[4];
      20: data = mregs[5];
      default: data = 32'h0;
    endcase
  endtask

  task automatic check_regs();
    chk("command", command, mregs[0]);
    chk("rxaddr", rxaddr, mregs[1]);
    chk("txaddr", txaddr, mregs[2]);
    chk("t", t, mregs[3]);
    chk("t_len", t_len, mregs[4]);
    chk("loading", loading, mregs[5]);
  endtask

  // Monitor: pops expectations on each B/R handshake and checks hold-while-stalled.
  initial begin
    logic [1:0] eb, er;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        b_stall = 1'b0;
        r_stall = 1'b0;
        continue;
      end
      if (b_stall) begin
        chk("bvalid_hold", 32'(bvalid), 32'd1);
        chk("bresp_hold", 32'(bresp), 32'(b_prev));
      end
      if (r_stall) begin
        chk("rvalid_hold", 32'(rvalid), 32'd1);
        chk("rdata_hold", rdata, r_prev_data);
        chk("rresp_hold", 32'(rresp), 32'(r_prev_resp));
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) timeout_fail("unexpected_b_response");
        else begin
          eb = bq.pop_front();
          chk("bresp", 32'(bresp), 32'(eb));
          check_regs();
        end
      end
      if (rvalid && rready) begin
        if (rq_data.size() == 0) timeout_fail("unexpected_r_response");
        else begin
          ed = rq_data.pop_front();
          er = rq_resp.pop_front();
          chk("rdata", rdata, ed);
          chk("rresp", 32'(rresp), 32'(er));
        end
      end
      b_stall     = bvalid && !bready;
      b_prev      = bresp;
      r_stall     = rvalid && !rready;
      r_prev_data = rdata;
      r_prev_resp = rresp;
    end
  end

  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      step();
      bready = ($urandom_range(0, 3) != 0);
      rready = r_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_empty(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (bq.size() == 0 && rq_data.size() == 0) done = 1'b1;
      else step();
    end
    if (!done) timeout_fail(name);
  endtask

  task automatic drive_aw(input logic [11:0] a, input bit linger);
    bit hs = 1'b0;
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = awready;
      step();
    end
    if (!hs) timeout_fail("aw_handshake");
    if (!linger) awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input bit linger);
    bit hs = 1'b0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = wready;
      step();
    end
    if (!hs) timeout_fail("w_handshake");
    if (!linger) wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [11:0] a);
    bit hs = 1'b0;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = arready;
      step();
    end
    if (!hs) timeout_fail("ar_handshake");
    arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned da, input int unsigned dw, input bit linger);
    logic [1:0] resp;
    model_write(a, d, s, resp);
    bq.push_back(resp);
    fork
      begin repeat (da) step(); drive_aw(a, linger); end
      begin repeat (dw) step(); drive_w(d, s, linger); end
    join
    chk("bvalid_latency", 32'(bvalid), 32'd1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_empty("b_response");
  endtask

  task automatic axi_read(input logic [11:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    model_read(a, d, r);
    rq_data.push_back(d);
    rq_resp.push_back(r);
    drive_ar(a);
    wait_empty("r_response");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    resetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0;
    status = 32'hCAFE0001; lsb_n = 32'h11112222; lsb_r_n = 32'h33334444; lsb_r2_n = 32'h55556666;
    for (int i = 0; i < 6; i++) mregs[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    check_regs();
    @(posedge clk);
    #1 resetn = 1'b1;
    step();
    step();
    chk("post_rst_awready", 32'(awready), 32'd1);
    chk("post_rst_wready", 32'(wready), 32'd1);
    chk("post_rst_arready", 32'(arready), 32'd1);

    axi_write(12'h004, 32'h0000_0100, 4'hF, 0, 0, 0);
    chk("rxaddr_direct", rxaddr, 32'h0000_0100);
    axi_write(12'h00C, 32'hAABB_CCDD, 4'b0101, 1, 0, 0);
    chk("t_strobed", t, 32'h00BB_00DD);
    axi_write(12'h014, 32'h0000_0009, 4'h1, 2, 0, 0);
    chk("loading_direct", loading, 32'h0000_0009);
    axi_read(12'h014);
    axi_write(12'h010, 32'h1234_5678, 4'hF, 0, 3, 1);
    axi_write(12'h018, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(12'h01C);
    axi_write(12'h040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(12'h040);

    // Stalled read: rready held low for five cycles after the AR handshake.
    status = 32'h1;
    @(negedge clk);
    r_hold = 1'b1;
    step();
    rq_data.push_back(32'h1);
    rq_resp.push_back(2'b00);
    drive_ar(12'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_rdata", rdata, 32'h1);
      chk("stall_arready", 32'(arready), 32'd0);
    end
    r_hold = 1'b0;
    wait_empty("stalled_read");

    for (int i = 0; i < 80; i++) begin
      status   = $urandom;
      lsb_n    = $urandom;
      lsb_r_n  = $urandom;
      lsb_r2_n = $urandom;
      a = ($urandom_range(0, 3) != 0) ? 12'($urandom_range(0, 31)) : 12'($urandom_range(32, 4095));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else
        axi_read(a);
    end

    // Reset while the write FSM holds an address but no data yet.
    axi_write(12'h000, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    drive_aw(12'h008, 0);
    chk("have_a_awready", 32'(awready), 32'd0);
    chk("have_a_wready", 32'(wready), 32'd1);
    resetn = 1'b0;
    #2;
    for (int i = 0; i < 6; i++) mregs[i] = 32'h0;
    check_regs();
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    step();
    step();
    chk("after_rst_bvalid", 32'(bvalid), 32'd0);
    axi_write(12'h008, 32'h1357_9BDF, 4'hF, 0, 0, 0);
    chk("txaddr_after_rst", txaddr, 32'h1357_9BDF);
    axi_read(12'h010);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
